prime_check: RTL and testbench
==============================

PRIME_CHECK -- requirements
Module: prime_check

Interface
REQ-001 SHALL have parameter WIDTH_LOG, default 4, log2 of data width; WIDTH = 1 << WIDTH_LOG.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port go  input  1  start request; sampled only while ready=1.
REQ-005 SHALL have port cand  input  WIDTH  candidate number; sampled only on an accepted go.
REQ-006 SHALL have port ready  output  1  idle, results valid.
REQ-007 SHALL have port error  output  1  last candidate was below 2.
REQ-008 SHALL have port is_prime  output  1  last candidate is prime.
REQ-009 SHALL have port factor  output  WIDTH  smallest nontrivial divisor of a composite candidate; 0 otherwise.

Function
REQ-010 SHALL decide primality by trial division: d = 2, 3, 5, 7, 9, ... (odd after 2), one divrem operation per d with num = latched cand, den = d.
REQ-011 SHALL implement the FSM states IDLE, CHECK, ISSUE and WAIT.
REQ-012 SHALL, in IDLE with go=1: latch cand; set ready=0 next cycle; move to CHECK; go with ready=0 is ignored.
REQ-013 SHALL, in CHECK, handle cand < 2: error=1, is_prime=0, factor=0; return to IDLE.
REQ-014 SHALL, in CHECK, handle cand of 2 or 3: is_prime=1, error=0, factor=0; return to IDLE (ready low exactly 1 cycle).
REQ-015 SHALL, in CHECK, handle cand >= 4: set d=2; move to ISSUE.
REQ-016 SHALL, in ISSUE, pulse divider go for exactly one cycle, then move to WAIT.
REQ-017 SHALL, in WAIT, hold the state until divider ready=1; divider num/den stay stable throughout.
REQ-018 SHALL, on divider completion with rem == 0, report composite: is_prime=0, factor=d, then IDLE.
REQ-019 SHALL, on divider completion with rem != 0 and quot < d (i.e. d*d > cand), report prime: is_prime=1, factor=0, then IDLE.
REQ-020 SHALL, on divider completion otherwise, advance d (2->3, else d+2) and return to ISSUE.
REQ-021 SHALL keep d at WIDTH bits; d never exceeds 2^(WIDTH/2)+1, so it cannot overflow.
REQ-022 SHALL set ready=1 in the same cycle the FSM re-enters IDLE.
REQ-023 SHALL hold error, is_prime and factor stable from completion until the next accepted go.
REQ-024 SHALL clear error, is_prime and factor when a go is accepted.
REQ-025 SHALL treat a divider error (den=0) as unreachable; flag it only under simulation assertions.

Reset
REQ-026 SHALL, asynchronously on rst_n=0, force IDLE, ready=1, error=0, is_prime=0, factor=0, d=0.
REQ-027 SHALL drive divider rst = ~rst_n; rst_n SHALL be held low >= 2 clk edges so the divider's synchronous reset takes effect.
REQ-028 SHALL, on reset mid-operation, abort the computation without a result; the first go after release starts cleanly.

Configuration
REQ-029 SHALL, with PRIME_CHECK_STATS_EN defined, add output div_cnt (WIDTH): number of divider operations in the last check; cleared on accepted go and on reset; saturates at all-ones.
REQ-030 SHALL, without PRIME_CHECK_STATS_EN, have neither the div_cnt port nor the counter; all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state encodings (2-bit IDLE/CHECK/ISSUE/WAIT) and the first-divisor/step constants in the shared package header.
REQ-032 SHALL instantiate exactly one divrem sub-module with the same WIDTH_LOG.

Verification
REQ-033 SHALL cover: cand=97 -> is_prime=1, factor=0, error=0; div_cnt=6 (d=2,3,5,7,9,11) when STATS enabled.
REQ-034 SHALL cover: cand=91 -> is_prime=0, factor=7; cand=64 -> factor=2; cand=25 -> factor=5.
REQ-035 SHALL cover: cand=0 and cand=1 -> error=1, is_prime=0; cand=2 -> is_prime=1 with ready low exactly 1 cycle.
REQ-036 SHALL cover: cand=65521 (WIDTH_LOG=4) -> is_prime=1; go pulses during busy are ignored and the result is unchanged.
REQ-037 SHALL cover: rst_n low for 3 cycles during WAIT of cand=65521 -> ready=1 and outputs 0 immediately; then cand=15 -> factor=3.

Source files
------------

// File: rtl/prime_check_pkg.sv
// prime_check_pkg: shared FSM encodings and trial-division constants for
// the prime_check block.
//   ST_IDLE/ST_CHECK/ST_ISSUE/ST_WAIT : 2-bit FSM state encodings
//   FIRST_DIV  : first trial divisor (2)
//   SECOND_DIV : divisor following 2 (3); also the largest trivially prime candidate
//   DIV_STEP   : increment between odd divisors once past 3
package prime_check_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam int FIRST_DIV  = 2;
  localparam int SECOND_DIV = 3;
  localparam int DIV_STEP   = 2;

endpackage

// File: rtl/prime_check_divrem.sv
// prime_check_divrem: iterative unsigned restoring divider, one quotient bit
// per clock (WIDTH cycles per operation).
//   clk   : clock
//   rst   : synchronous active-high reset (control state only)
//   go    : start request, accepted while ready=1
//   num   : dividend, sampled on accepted go
//   den   : divisor, sampled on accepted go
//   ready : idle; quot/rem valid after an operation
//   quot  : quotient
//   rem   : remainder
//   error : divide by zero in progress
module prime_check_divrem #(
  parameter int WIDTH_LOG = 4,
  localparam int WIDTH = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             error
);

  localparam int CNT_W = WIDTH_LOG + 1;

  logic             ready_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] quot_p0;
  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] den_p0;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   diff;
  logic             ge;

  // Partial remainder stays below 2*den, so after a subtraction it fits WIDTH bits.
  always_comb begin
    part = {rem_p0, quot_p0[WIDTH-1]};
    diff = part - {1'b0, den_p0};
    ge   = (part >= {1'b0, den_p0});
  end

  // Control: iteration counter and ready
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_p0 <= 1'b1;
      cnt_p0   <= '0;
    end else if (ready_p0) begin
      if (go) begin
        ready_p0 <= 1'b0;
        cnt_p0   <= CNT_W'(WIDTH);
      end
    end else begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
      if (cnt_p0 == CNT_W'(1)) begin
        ready_p0 <= 1'b1;
      end
    end
  end

  // Data: dividend shifts out of quot_p0 while quotient bits shift in
  always_ff @(posedge clk) begin
    if (ready_p0 && go) begin
      quot_p0 <= num;
      rem_p0  <= '0;
      den_p0  <= den;
    end else if (!ready_p0) begin
      quot_p0 <= {quot_p0[WIDTH-2:0], ge};
      rem_p0  <= ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    end
  end

  assign ready = ready_p0;
  assign quot  = quot_p0;
  assign rem   = rem_p0;
  assign error = !ready_p0 && (den_p0 == '0);

endmodule

// File: rtl/prime_check.sv
// prime_check: trial-division primality tester built around one iterative
// divider. Divisors tried are 2, 3, 5, 7, 9, ...; the search stops at the
// first zero remainder (composite) or once d*d exceeds the candidate (prime).
// Optional feature macro: PRIME_CHECK_STATS_EN adds the div_cnt output.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (hold >= 2 edges so the divider resets)
//   go       : start request, sampled while ready=1
//   cand     : candidate number, sampled on accepted go
//   ready    : idle, results valid
//   error    : last candidate was below 2
//   is_prime : last candidate is prime
//   factor   : smallest nontrivial divisor of a composite candidate, else 0
//   div_cnt  : (PRIME_CHECK_STATS_EN only) divider operations in the last check
module prime_check
  import prime_check_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  localparam int WIDTH = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] cand,
  output logic             ready,
  output logic             error,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor
`ifdef PRIME_CHECK_STATS_EN
  ,
  output logic [WIDTH-1:0] div_cnt
`endif
);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] cand_p0;
  logic [WIDTH-1:0] d_p0;
  logic             div_go;
  logic             div_ready;
  logic             div_error;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && go;
  assign div_go = (state_q == ST_ISSUE);

  prime_check_divrem #(
    .WIDTH_LOG (WIDTH_LOG)
  ) u_divrem (
    .clk   (clk),
    .rst   (~rst_n),
    .go    (div_go),
    .num   (cand_p0),
    .den   (d_p0),
    .ready (div_ready),
    .quot  (div_quot),
    .rem   (div_rem),
    .error (div_error)
  );

  // Candidate latch: data only, no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      cand_p0 <= cand;
    end
  end

  // Control FSM and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready    <= 1'b1;
      error    <= 1'b0;
      is_prime <= 1'b0;
      factor   <= '0;
      d_p0     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            ready    <= 1'b0;
            error    <= 1'b0;
            is_prime <= 1'b0;
            factor   <= '0;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cand_p0 < WIDTH'(FIRST_DIV)) begin
            error   <= 1'b1;
            ready   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (cand_p0 <= WIDTH'(SECOND_DIV)) begin
            is_prime <= 1'b1;
            ready    <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            d_p0    <= WIDTH'(FIRST_DIV);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_ready) begin
            if (div_rem == '0) begin
              factor  <= d_p0;
              ready   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (div_quot < d_p0) begin
              // quot < d means d*d > cand: no smaller factor remains untested
              is_prime <= 1'b1;
              ready    <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              d_p0    <= (d_p0 == WIDTH'(FIRST_DIV)) ? WIDTH'(SECOND_DIV)
                                                      : d_p0 + WIDTH'(DIV_STEP);
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PRIME_CHECK_STATS_EN
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (accept) begin
      div_cnt <= '0;
    end else if (div_go) begin
      div_cnt <= sat_inc(div_cnt);
    end
  end
`else
  // No operation counter in this build; div_go feeds only the divider.
`endif

  // d is loaded with a nonzero value in CHECK before any issue, so a zero
  // divisor can only mean a broken FSM.
  a_no_div_error: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == ST_WAIT) |-> !div_error);

endmodule

// File: tb/tb_prime_check.sv
module tb_prime_check;

  localparam int WIDTH_LOG = 4;
  localparam int WIDTH     = 1 << WIDTH_LOG;
  localparam int BUDGET    = 5000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic [WIDTH-1:0] cand;
  logic             ready;
  logic             error;
  logic             is_prime;
  logic [WIDTH-1:0] factor;
`ifdef PRIME_CHECK_STATS_EN
  logic [WIDTH-1:0] div_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   cand;
    logic err;
    logic prime;
    int   factor;
    int   ops;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  prime_check #(
    .WIDTH_LOG (WIDTH_LOG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .cand     (cand),
    .ready    (ready),
    .error    (error),
    .is_prime (is_prime),
    .factor   (factor)
`ifdef PRIME_CHECK_STATS_EN
    ,
    .div_cnt  (div_cnt)
`endif
  );

  // Reference: primality and smallest factor by exhaustive search; operation
  // count by walking the divisor sequence 2,3,5,7,...
  function automatic exp_t model(input int c);
    exp_t e;
    int   d;
    e.cand   = c;
    e.err    = (c < 2);
    e.prime  = 1'b0;
    e.factor = 0;
    e.ops    = 0;
    if (c >= 2) begin
      for (int k = 2; k * k <= c; k++) begin
        if (c % k == 0) begin
          e.factor = k;
          break;
        end
      end
      e.prime = (e.factor == 0);
    end
    if (c >= 4) begin
      d = 2;
      while (1) begin
        e.ops++;
        if (c % d == 0) break;
        if (c / d < d) break;
        d = (d == 2) ? 3 : d + 2;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int c);
    int cyc;
    cyc = 0;
    while (!ready && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    go   = 1'b1;
    cand = WIDTH'(c);
    sb.push_back(model(c));
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic finish(output int busy);
    exp_t e;
    busy = 0;
    while (!ready && busy < BUDGET) begin
      busy++;
      @(negedge clk);
    end
    check("done_in_budget", 32'(ready), 1);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("error[%0d]", e.cand), 32'(error), 32'(e.err));
      check($sformatf("is_prime[%0d]", e.cand), 32'(is_prime), 32'(e.prime));
      check($sformatf("factor[%0d]", e.cand), 32'(factor), e.factor);
`ifdef PRIME_CHECK_STATS_EN
      check($sformatf("div_cnt[%0d]", e.cand), 32'(div_cnt), e.ops);
`endif
    end
  endtask

  task automatic run(input int c, output int busy);
    start(c);
    finish(busy);
  endtask

  initial begin
    int busy;
    int table_c[8] = '{4, 9, 15, 121, 255, 65535, 65534, 257};

    rst_n = 1'b0;
    go    = 1'b0;
    cand  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_error", 32'(error), 0);
    check("rst_is_prime", 32'(is_prime), 0);
    check("rst_factor", 32'(factor), 0);
`ifdef PRIME_CHECK_STATS_EN
    check("rst_div_cnt", 32'(div_cnt), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run(97, busy);
    run(91, busy);

    // Accepted go clears the previous result (factor 7 from 91)
    start(97);
    check("clear_ready", 32'(ready), 0);
    check("clear_factor", 32'(factor), 0);
    check("clear_is_prime", 32'(is_prime), 0);
    finish(busy);

    run(64, busy);
    run(25, busy);
    run(0, busy);
    check("busy_cycles[0]", busy, 1);
    run(1, busy);
    check("busy_cycles[1]", busy, 1);
    run(2, busy);
    check("busy_cycles[2]", busy, 1);
    run(3, busy);
    check("busy_cycles[3]", busy, 1);

    foreach (table_c[i]) run(table_c[i], busy);

    // Go pulses while busy must be ignored
    start(65521);
    for (int i = 0; i < 4; i++) begin
      repeat (7) @(negedge clk);
      go   = 1'b1;
      cand = WIDTH'(91);
      @(negedge clk);
      go = 1'b0;
    end
    finish(busy);
    repeat (5) @(negedge clk);
    check("hold_is_prime", 32'(is_prime), 1);
    check("hold_factor", 32'(factor), 0);
    check("hold_ready", 32'(ready), 1);

    // Reset while the divider is mid-operation aborts without a result
    start(65521);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 1);
    check("abort_error", 32'(error), 0);
    check("abort_is_prime", 32'(is_prime), 0);
    check("abort_factor", 32'(factor), 0);
`ifdef PRIME_CHECK_STATS_EN
    check("abort_div_cnt", 32'(div_cnt), 0);
`endif
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(15, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
